// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment constants and active-high glyph table
package seg7_pkg;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam logic [6:0] SEG_BLANK_AH = 7'h00;
  localparam logic [6:0] SEG7_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational nibble to active-high segment pattern (bit 0 = a)
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);
  // Direct table lookup; an X nibble yields X segments rather than a masked glyph
  always_comb seg_o = SEG7_GLYPH[nibble_i];
endmodule

// File: rtl/decoder_7_segment.sv
// decoder_7_segment: registered hex-to-seven-segment decoder with polarity select
module decoder_7_segment
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] char,
  output logic [6:0] LED
);
  localparam logic [6:0] BLANK = ACTIVE_LOW ? ~SEG_BLANK_AH : SEG_BLANK_AH;
  logic [6:0] seg_ah;
  logic [6:0] led_d;
  logic [6:0] led_q;
  hex_to_seg7 u_lut (
    .nibble_i(char),
    .seg_o   (seg_ah)
  );
  // Apply board polarity before the flop so the pins see only registered levels
  always_comb led_d = ACTIVE_LOW ? ~seg_ah : seg_ah;
  // Output register; reset blanks the digit immediately
  always_ff @(posedge clk or posedge rst)
    if (rst) led_q <= BLANK;
    else led_q <= led_d;
  assign LED = led_q;
endmodule

// File: tb/tb_decoder_7_segment.sv
// tb_decoder_7_segment: directed checks of both polarity builds
module tb_decoder_7_segment;
  logic       clk;
  logic       rst;
  logic [3:0] char;
  logic [6:0] led_al;
  logic [6:0] led_ah;
  logic [6:0] cur;
  int         pass_cnt = 0;
  int         total = 0;
  logic [6:0] tbl [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  decoder_7_segment #(.ACTIVE_LOW(1'b1)) dut_al (
    .clk (clk),
    .rst (rst),
    .char(char),
    .LED (led_al)
  );

  decoder_7_segment #(.ACTIVE_LOW(1'b0)) dut_ah (
    .clk (clk),
    .rst (rst),
    .char(char),
    .LED (led_ah)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic both(input string tag, input logic [6:0] exp_al);
    chk({tag, "_al"}, led_al, exp_al);
    chk({tag, "_ah"}, led_ah, ~exp_al);
  endtask

  task automatic step(input logic [3:0] v);
    @(negedge clk);
    char = v;
    #1 both("hold", cur);
    @(posedge clk);
    #1 cur = tbl[v];
    both($sformatf("dec%h", v), cur);
  endtask

  initial begin
    rst  = 1'b0;
    char = 4'h8;
    @(negedge clk);
    rst = 1'b1;
    #1 cur = 7'h7F;
    both("rst_async", cur);
    repeat (3) @(posedge clk);
    #1 both("rst_hold", cur);
    @(negedge clk);
    rst = 1'b0;
    #1 both("rst_rel_pre", cur);
    @(posedge clk);
    #1 cur = 7'h00;
    both("rst_rel", cur);
    for (int i = 0; i < 16; i++) step(4'(i));
    step(4'h8);
    step(4'h9);
    step(4'h3);
    @(negedge clk);
    char = 4'h7;
    #1 both("lat_a", 7'h30);
    #3 both("lat_b", 7'h30);
    @(posedge clk);
    #1 cur = 7'h78;
    both("lat_new", cur);
    step(4'h0);
    step(4'hC);
    step(4'hE);
    @(negedge clk);
    char = 4'h1;
    rst  = 1'b1;
    #1 cur = 7'h7F;
    both("rst_mid", cur);
    @(posedge clk);
    #1 both("rst_mid_edge", cur);
    @(negedge clk);
    char = 4'hE;
    rst  = 1'b0;
    @(posedge clk);
    #1 cur = 7'h06;
    both("rst_mid_rel", cur);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/decoder_7_segment.md
# decoder_7_segment

Registered hexadecimal-to-seven-segment decoder. It converts a 4-bit nibble `char` into the seven segment-drive lines `LED` for one digit. It sits between the digit-select/multiplexing logic of the four-digit display driver and the board's segment pins. All 16 codes decode, 0-9 and A-F (b and d in lower case), and the output is registered so the pins are glitch-free.

## Interface
- `ACTIVE_LOW`, default 1: 1 means a lit segment is driven 0 (common-anode board); 0 means a lit segment is driven 1.
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high; forces `LED` to all segments off.
- `char`  in  4  hex digit to display, 4'h0-4'hF.
- `LED`  out  7  segment drive; bit order [6:0] = g f e d c b a (bit 0 = segment a).

## Operation
- Segment sets lit per code (standard a-g naming):
  - 0 abcdef; 1 bc; 2 abdeg; 3 abcdg
  - 4 bcfg; 5 acdfg; 6 acdefg; 7 abc
  - 8 abcdefg; 9 abcdfg; A abcefg; b cdefg
  - C adef; d bcdeg; E adefg; F aefg
- Resulting `LED` values with `ACTIVE_LOW`=1, codes 0..F in order: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E (hex).
- With `ACTIVE_LOW`=0, `LED` is the bitwise inverse of the value above.
- Blank (all segments off) = 7'h7F when active-low, 7'h00 when active-high.
- The lookup is a full case over all 16 codes; there is no default/illegal path.
- An X or Z on `char` must not be masked. Simulation may propagate X to `LED`.

## Timing
- Latency is 1 clock: `LED` after rising edge N reflects `char` sampled at edge N.
- Reset:
  - While `rst`=1, `LED` = blank, regardless of `clk` or `char`.
  - Assertion takes effect immediately, without waiting for a clock edge.
  - After deassertion, the first rising edge loads the decode of the current `char`.
- Reset asserted between edges blanks the output at once, and the pending update is lost.
- `char` changing every cycle gives a new decode every cycle. There is no hold or handshake.
- `char` must meet setup/hold to `clk`. Synchronizing asynchronous sources is the upstream driver's job.
- `LED` is driven only from flops, never from a combinational path.

## Structure
- Shared package `seg7_pkg`:
  - segment-index constants SEG_A..SEG_G (0..6)
  - the 16-entry active-high glyph constant array
  - the `SEG_BLANK_AH` constant
- Sub-module `hex_to_seg7`: purely combinational nibble-to-active-high-pattern lookup.
- Top level `decoder_7_segment` instantiates `hex_to_seg7`, applies `ACTIVE_LOW` inversion, and holds the 7-bit output register with async reset.
- The four-digit driver reuses `hex_to_seg7` unchanged.

## Test plan
- Reset: assert `rst` mid-cycle with `char`=4'h8 -> `LED`=7'h7F immediately. Hold 3 clocks -> stays 7'h7F. Release -> next edge gives 7'h00.
- Full sweep, `ACTIVE_LOW`=1: `char` 0..F one per clock -> `LED` follows the 16-value list one cycle later, e.g. 4'h0->7'h40, 4'h1->7'h79, 4'hA->7'h08, 4'hF->7'h0E.
- Codes 8 and 9 back to back -> 7'h00 then 7'h10, each exactly one cycle after the input.
- Latency: change `char` 4'h3->4'h7 between edges -> `LED` holds 7'h30 until the next rising edge, then shows 7'h78. No intermediate value appears.
- `ACTIVE_LOW`=0 build: `char`=4'h0 -> 7'h3F; 4'hC -> 7'h39; reset -> 7'h00.
- Async reset mid-sweep at `char`=4'hE -> `LED`=7'h7F within the same cycle. After release, first edge gives 7'h06.
